// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_framer
// Function : Latches up to MAX_BYTES message bytes and sends them, byte 0 first,
//            as UART 8N1; define UART_TX_PARITY_EN for an even-parity bit (8E1).
// Revision : 1.0
// ============================================================================
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_BYTES    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*MAX_BYTES-1:0] tx_show,
  input  logic [4:0]             show_len,
  input  logic                   send,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   tx
);

  localparam int          MSG_W     = 8 * MAX_BYTES;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  LEN_MAX   = 5'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [4:0]         byte_q, byte_d;
  logic [4:0]         len_q, len_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  logic               baud_wrap;
  logic [7:0]         cur_byte;

  // The byte on the wire always sits in the top of the shift buffer.
  assign cur_byte  = msg_q[MSG_W-1 -: 8];
  assign baud_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    msg_d   = msg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_wrap ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send && (show_len != 5'd0)) begin
          state_d = S_START;
          msg_d   = tx_show;
          len_d   = (show_len > LEN_MAX) ? LEN_MAX : show_len;
          byte_d  = 5'd0;
          bit_d   = 3'd0;
          baud_d  = 16'd0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^cur_byte;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_wrap) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_wrap) begin
          // Last byte returns to idle with done; otherwise the next start bit follows immediately.
          if (byte_q == len_q - 5'd1) begin
            state_d = S_IDLE;
            byte_d  = 5'd0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 5'd1;
            msg_d   = {msg_q[MSG_W-9:0], 8'h00};
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 5'd0;
      len_q   <= 5'd0;
      msg_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      msg_q   <= msg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign done  = done_q;
  assign tx    = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_framer
// Function : Self-checking bench for uart_tx_framer with a UART receiver scoreboard.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_framer;

  localparam int CPB   = 4;
  localparam int MAXB  = 16;
  localparam int MSG_W = 8 * MAXB;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic             clk;
  logic             reset;
  logic [MSG_W-1:0] tx_show;
  logic [4:0]       show_len;
  logic             send;
  logic             ready, busy, done, tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_show  (tx_show),
    .show_len (show_len),
    .send     (send),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected serial level of frame slot idx for data byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Receiver: samples mid-bit on falling clock edges and scores each byte at its stop bit.
  bit         rx_active = 1'b0;
  int         rx_cnt    = 0;
  int         rx_slot;
  logic [7:0] rx_byte;
  logic       rx_par;
  logic [7:0] rx_exp;

  initial begin
    rx_par = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          rx_slot = rx_cnt / CPB;
          if (rx_slot >= 1 && rx_slot <= 8) begin
            rx_byte[rx_slot-1] = tx;
          end else if (rx_slot == NB - 1) begin
            rx_active = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rx_byte: got %h but no byte was expected", rx_byte);
            end else begin
              rx_exp = exp_q.pop_front();
              if (rx_byte !== rx_exp || tx !== 1'b1) begin
                errors++;
                $display("FAIL rx_byte: got %h stop %b, expected %h stop 1", rx_byte, tx, rx_exp);
              end
`ifdef UART_TX_PARITY_EN
              checks++;
              if (rx_par !== ^rx_exp) begin
                errors++;
                $display("FAIL rx_parity: got %b expected %b for byte %h", rx_par, ^rx_exp, rx_exp);
              end
`endif
            end
          end else begin
            rx_par = tx;
          end
        end
      end
    end
  end

  // Drives a one-cycle send at the current falling edge; returns at the falling edge after the accept edge.
  task automatic start_msg(input logic [MSG_W-1:0] msg, input logic [4:0] len, input bit accepted);
    int n;
    tx_show  = msg;
    show_len = len;
    send     = 1'b1;
    n = (int'(len) > MAXB) ? MAXB : int'(len);
    if (accepted) begin
      for (int i = 0; i < n; i++) exp_q.push_back(msg[MSG_W-1-8*i -: 8]);
    end
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int busy_cnt, output int done_at);
    busy_cnt = 0;
    done_at  = -1;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit quiet;
    reset    = 1'b1;
    send     = 1'b0;
    tx_show  = '0;
    show_len = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs: tx/ready/busy/done got %b expected 1100", {tx, ready, busy, done});
    end
    quiet = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_idle_line: idle line moved, got %b expected 1", quiet);
    end
  endtask

  task automatic test_single_byte();
    logic exp_bit;
    start_msg({8'h41, 120'h0}, 5'd1, 1'b1);
    for (int k = 0; k < FRAME_CYC; k++) begin
      exp_bit = frame_bit(8'h41, k / CPB);
      checks++;
      if (tx !== exp_bit) begin
        errors++;
        $display("FAIL single_tx_level: cycle %0d got %b expected %b", k, tx, exp_bit);
      end
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL single_busy: cycle %0d busy/ready/done got %b%b%b expected 100", k, busy, ready, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done/ready got %b%b expected 11 at cycle %0d", done, ready, FRAME_CYC);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_after: done %b pending %0d expected done 0 pending 0", done, exp_q.size());
    end
  endtask

  task automatic test_multi_byte();
    int busy_cnt, done_at;
    start_msg({32'h70617373, 96'h0}, 5'd4, 1'b1);
    run_to_done(4 * FRAME_CYC + 50, busy_cnt, done_at);
    checks++;
    if (busy_cnt != 4 * FRAME_CYC) begin
      errors++;
      $display("FAIL multi_busy_cycles: got %0d expected %0d", busy_cnt, 4 * FRAME_CYC);
    end
    checks++;
    if (done_at != 4 * FRAME_CYC || exp_q.size() != 0) begin
      errors++;
      $display("FAIL multi_done: done at %0d pending %0d expected %0d pending 0", done_at, exp_q.size(), 4 * FRAME_CYC);
    end
    @(negedge clk);
  endtask

  task automatic test_len_edges();
    bit quiet;
    logic [MSG_W-1:0] msg;
    int busy_cnt, done_at;
    start_msg({8'hAA, 120'h0}, 5'd0, 1'b0);
    quiet = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL len_zero: line or ready moved, got %b expected 1", quiet);
    end
    for (int i = 0; i < MSG_W / 32; i++) msg[32*i +: 32] = $urandom;
    start_msg(msg, 5'd31, 1'b1);
    run_to_done(16 * FRAME_CYC + 50, busy_cnt, done_at);
    checks++;
    if (done_at != 16 * FRAME_CYC || busy_cnt != 16 * FRAME_CYC || exp_q.size() != 0) begin
      errors++;
      $display("FAIL len_clamp: done at %0d busy %0d pending %0d expected %0d/%0d/0",
               done_at, busy_cnt, exp_q.size(), 16 * FRAME_CYC, 16 * FRAME_CYC);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int busy_cnt, done_at;
    start_msg({8'hC3, 8'h5A, 112'h0}, 5'd2, 1'b1);
    repeat (15) @(negedge clk);
    tx_show  = {MSG_W{1'b1}};
    show_len = 5'd3;
    send     = 1'b1;
    @(negedge clk);
    send = 1'b0;
    run_to_done(2 * FRAME_CYC + 50, busy_cnt, done_at);
    checks++;
    if (done_at + 16 != 2 * FRAME_CYC || ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_send_ignored: done at %0d ready %b expected %0d ready 1",
               done_at + 16, ready, 2 * FRAME_CYC);
    end
    start_msg({8'h0F, 120'h0}, 5'd1, 1'b1);
    checks++;
    if (tx !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: tx/ready/busy got %b%b%b expected 001", tx, ready, busy);
    end
    run_to_done(FRAME_CYC + 50, busy_cnt, done_at);
    checks++;
    if (done_at != FRAME_CYC || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_done: done at %0d pending %0d expected %0d pending 0", done_at, exp_q.size(), FRAME_CYC);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit quiet;
    int busy_cnt, done_at;
    start_msg({8'h55, 8'hA3, 112'h0}, 5'd2, 1'b1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({tx, ready, done} !== 3'b110) begin
      errors++;
      $display("FAIL reset_mid: tx/ready/done got %b expected 110", {tx, ready, done});
    end
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (tx !== 1'b1 || done !== 1'b0 || ready !== 1'b1) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity after reset, got %b expected 1", quiet);
    end
    start_msg({8'h41, 120'h0}, 5'd1, 1'b1);
    run_to_done(FRAME_CYC + 50, busy_cnt, done_at);
    checks++;
    if (done_at != FRAME_CYC || busy_cnt != FRAME_CYC || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_resend: done at %0d busy %0d pending %0d expected %0d/%0d/0",
               done_at, busy_cnt, exp_q.size(), FRAME_CYC, FRAME_CYC);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_len_edges();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Downstream consumer of the CPU top's debug message outputs (tx_show, show_len).
- Latches a message of up to 16 bytes and serializes it on a UART 8N1 line, one byte after another.
- Gives the FPGA build a visible channel for what the simulation bench checks through its display messages.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- MAX_BYTES, 16, capacity of the message buffer; tx_show is 8*MAX_BYTES bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_show  input  8*MAX_BYTES  message; byte 0 = most significant byte [127:120], sent first.
- show_len  input  5  number of bytes to send; values above MAX_BYTES are clamped to MAX_BYTES.
- send  input  1  request; accepted only when ready=1.
- ready  output  1  high when idle and able to accept send.
- busy  output  1  high while a message is being transmitted (equals ~ready).
- done  output  1  one-cycle pulse after the last stop bit of a message.
- tx  output  1  serial line, idle high.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: tx=1, ready=1, busy=0, done=0; state=IDLE; bit, baud and byte counters = 0.
- Accept: send=1 and ready=1 at edge N.
  - Latch tx_show and clamp(show_len); ready drops at N+1.
  - tx=0 (start bit) from N+1.
  - Inputs are not sampled again until the next accept.
- show_len=0 with send: request is ignored; ready stays 1, no done pulse, tx stays 1.
- send while busy: ignored; no queuing.
- States and transitions:
  - IDLE: tx=1; on accept go to START.
  - START: tx=0 for CLKS_PER_BIT cycles; then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; then STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. If bytes remain, go to START with no idle gap. Otherwise go to IDLE, assert done for one cycle, and set ready=1 in that same cycle.
- Frame timing: each byte is 10*CLKS_PER_BIT cycles. A message of L bytes holds busy for exactly L*10*CLKS_PER_BIT cycles.
- Back-to-back messages: send may be asserted in the done cycle; that request is accepted and its start bit begins on the following cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter advances only on baud counter wrap.
- Byte pointer: 0..L-1; the comparison against L is made at the end of STOP.
- Reset mid-frame: on the next edge tx=1 and ready=1, the message is discarded, and no done pulse is generated.
- tx is driven from a register (glitch-free); there is no combinational path from any input to tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Each frame becomes 11*CLKS_PER_BIT cycles.
- When undefined: plain 8N1 as above; no PARITY state is synthesized.

Test Plan:
- Reset held 3 cycles, then released -> tx=1, ready=1, busy=0, done=0. With send=0 for 100 cycles, tx stays 1.
- CLKS_PER_BIT=4, tx_show[127:120]=8'h41, show_len=1, pulse send -> tx sequence is 0,1,0,0,0,0,0,1,0,1, each level held 4 cycles. done pulses exactly 40 cycles after the accept edge, and ready=1 in that same cycle.
- CLKS_PER_BIT=4, tx_show=ASCII "pass" in the top 4 bytes, show_len=4 -> a bench UART receiver decodes 8'h70, 8'h61, 8'h73, 8'h73 in order, with no gaps. busy is high for 160 cycles.
- show_len=0 with send -> no start bit and no done; ready stays 1. show_len=31 -> exactly 16 bytes are sent.
- Assert send again at cycle 15 of a busy message -> ignored: the bytes sent and done timing are unchanged. A send asserted in the done cycle starts a new frame on the next cycle.
- Assert reset at cycle 20 of a 2-byte message -> tx=1 and ready=1 on the next edge, with no done pulse. A fresh send afterwards transmits normally; with UART_TX_PARITY_EN, 8'h41 carries parity bit 0 and the frame is 44 cycles.
